uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (8N1 serializer with a one-cycle `start` input, an 8-bit data input and a one-cycle `txdone` pulse) between NUM_REQ byte producers.
- Round-robin grant per byte, or per packet when a requester holds the grant with `req_last`=0.
- Sequences the serializer: launch, wait for done, enforce an inter-frame gap, then re-arbitrate.
- Sits between system producers (debug, status, loopback) and the UART TX/RX block.

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
// Holds the sequencer state encoding and the default requester/byte geometry.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    // Grant index width; a single requester still needs one bit to name itself.
    function automatic int gnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a down/up counter that must be able to hold the value n.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

    localparam int GNT_W_DEF = gnt_w(NUM_REQ_DEF);

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: scans last_gnt+1, last_gnt+2, ...
// with wrap and reports the first asserted request.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int GNT_W   = GNT_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   last_gnt,
    output logic               found,
    output logic [GNT_W-1:0]   idx
);

    function automatic logic [GNT_W-1:0] wrap(input int v);
        return GNT_W'(v % NUM_REQ);
    endfunction

    // The previous winner is visited last, so it only wins again when alone.
    always_comb begin
        found = 1'b0;
        idx   = last_gnt;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[wrap(int'(last_gnt) + k)]) begin
                found = 1'b1;
                idx   = wrap(int'(last_gnt) + k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART serializer between NUM_REQ byte producers with
// round-robin, packet-lockable grants. Optional watchdog: `UART_ARB_WDOG_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ     = NUM_REQ_DEF,
    parameter int  DATA_W      = DATA_W_DEF,
    parameter int  GAP_CYCLES  = 4,
    parameter int  WDOG_CYCLES = 20000,
    localparam int GNT_W       = gnt_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      uart_start,
    output logic [DATA_W-1:0]         uart_txin,
    input  logic                      uart_txdone,
    output logic [GNT_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      wdog_err
);

    localparam int GAP_W = cnt_w(GAP_CYCLES);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              lock;
    logic [GAP_W-1:0]  gap_cnt;

    logic              rr_found;
    logic [GNT_W-1:0]  rr_idx;
    logic              pick_found;
    logic [GNT_W-1:0]  pick_idx;
    logic [DATA_W-1:0] pick_data;
    logic              pick_last;

    logic              accept;
    logic              gap_load;
    logic              wdog_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_rr_pick (
        .req      (req_valid),
        .last_gnt (grant_id),
        .found    (rr_found),
        .idx      (rr_idx)
    );

    // A locked packet pins eligibility to the current holder; nobody else is looked at.
    always_comb begin
        if (lock) begin
            pick_found = req_valid[grant_id];
            pick_idx   = grant_id;
        end else begin
            pick_found = rr_found;
            pick_idx   = rr_idx;
        end
        pick_data = req_data[int'(pick_idx) * DATA_W +: DATA_W];
        pick_last = req_last[pick_idx];
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        gap_load   = 1'b0;
        uart_start = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found && !rst) begin
                    accept    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                uart_start = 1'b1;
                state_nxt  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (uart_txdone || wdog_hit) begin
                    gap_load  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

`ifdef UART_ARB_WDOG_EN
    localparam int WD_W = cnt_w(WDOG_CYCLES);

    logic [WD_W-1:0] wdog_cnt;

    // Counts only while a frame is outstanding; any other state rearms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign wdog_hit = (state == WAIT_DONE) && !uart_txdone &&
                      (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
`else
    // Constant zero; the limit only has meaning with the watchdog built in.
    assign wdog_hit = 1'b0 && (WDOG_CYCLES != 0);
`endif

    assign wdog_err = wdog_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lock      <= 1'b0;
            grant_id  <= GNT_W'(NUM_REQ - 1);
            uart_txin <= '0;
            gap_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                uart_txin <= pick_data;
                grant_id  <= pick_idx;
                lock      <= ~pick_last;
            end else if (wdog_hit) begin
                lock <= 1'b0;
            end
            if (gap_load) begin
                gap_cnt <= GAP_W'(GAP_CYCLES);
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the serializer's txdone is
// driven by hand and producers are small per-requester byte lists.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GAP = 4;
    localparam int WD  = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             uart_start;
    logic [W-1:0]     uart_txin;
    logic             uart_txdone;
    logic [1:0]       grant_id;
    logic             busy;
    logic             wdog_err;

    int total = 0;
    int bad   = 0;
    int acc   = 0;

    logic [8:0] pmem [N][8];
    int         pcnt [N];
    int         pidx [N];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .DATA_W      (W),
        .GAP_CYCLES  (GAP),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .uart_start  (uart_start),
        .uart_txin   (uart_txin),
        .uart_txdone (uart_txdone),
        .grant_id    (grant_id),
        .busy        (busy),
        .wdog_err    (wdog_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (pidx[i] < pcnt[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = pmem[i][pidx[i]][7:0];
                req_last[i]        = pmem[i][pidx[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = '0;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int r, input logic [7:0] d, input logic l);
        pmem[r][pcnt[r]] = {l, d};
        pcnt[r]++;
        refresh();
    endtask

    task automatic clearQueues();
        for (int i = 0; i < N; i++) begin
            pcnt[i] = 0;
            pidx[i] = 0;
        end
        refresh();
    endtask

    // Advance one cycle: producers that saw ready move to their next byte.
    task automatic step();
        logic [N-1:0] pend;
        pend = req_ready;
        acc += $countones(req_ready);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (pend[i]) pidx[i]++;
        end
        refresh();
        #1;
    endtask

    task automatic doReset();
        rst         = 1'b1;
        uart_txdone = 1'b0;
        clearQueues();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic waitStart();
        bit seen;
        seen = 1'b0;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (uart_start) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checkOutput("launch_seen", 32'(seen), 1);
    endtask

    task automatic waitIdle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checkOutput("idle_seen", 32'(seen), 1);
    endtask

    task automatic pulseDone();
        uart_txdone = 1'b1;
        step();
        uart_txdone = 1'b0;
    endtask

    task automatic runFrame(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_gid);
        int a0;
        a0 = acc;
        waitStart();
        checkOutput({tag, "_data"}, 32'(uart_txin), 32'(exp_data));
        checkOutput({tag, "_gid"}, 32'(grant_id), 32'(exp_gid));
        step();
        step();
        pulseDone();
        waitIdle();
        checkOutput({tag, "_accepts"}, 32'(acc - a0), 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int n;
        int a0;
        logic [7:0] fair_data [6];
        logic [1:0] fair_gid  [6];

        rst         = 1'b0;
        uart_txdone = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        clearQueues();
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(req_ready), 0);
        checkOutput("rst_start", 32'(uart_start), 0);
        checkOutput("rst_txin", 32'(uart_txin), 0);
        checkOutput("rst_gid", 32'(grant_id), 3);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_wdog", 32'(wdog_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        $display("[TB] single byte");
        applyStimulus(0, 8'hA5, 1'b1);
        #1;
        checkOutput("single_ready", 32'(req_ready), 32'h1);
        checkOutput("single_busy_idle", 32'(busy), 0);
        checkOutput("single_start_early", 32'(uart_start), 0);
        step();
        checkOutput("single_start", 32'(uart_start), 1);
        checkOutput("single_txin", 32'(uart_txin), 32'hA5);
        checkOutput("single_gid", 32'(grant_id), 0);
        checkOutput("single_ready_off", 32'(req_ready), 0);
        step();
        checkOutput("single_start_once", 32'(uart_start), 0);
        checkOutput("single_busy_wait", 32'(busy), 1);
        step();
        pulseDone();
        repeat (3) step();
        checkOutput("single_busy_d4", 32'(busy), 1);
        step();
        checkOutput("single_busy_d5", 32'(busy), 0);

        $display("[TB] fairness");
        doReset();
        applyStimulus(0, 8'hC0, 1'b1);
        applyStimulus(1, 8'hC1, 1'b1);
        applyStimulus(2, 8'hC2, 1'b1);
        applyStimulus(3, 8'hC3, 1'b1);
        applyStimulus(0, 8'hD0, 1'b1);
        applyStimulus(1, 8'hD1, 1'b1);
        fair_data = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1};
        fair_gid  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 6; k++) begin
            runFrame($sformatf("fair%0d", k), fair_data[k], fair_gid[k]);
        end

        $display("[TB] packet lock");
        doReset();
        applyStimulus(1, 8'h11, 1'b0);
        applyStimulus(1, 8'h22, 1'b0);
        applyStimulus(1, 8'h33, 1'b1);
        applyStimulus(2, 8'h99, 1'b1);
        runFrame("pkt0", 8'h11, 2'd1);
        runFrame("pkt1", 8'h22, 2'd1);
        runFrame("pkt2", 8'h33, 2'd1);
        runFrame("pkt3", 8'h99, 2'd2);

        $display("[TB] lock hold");
        doReset();
        applyStimulus(1, 8'h44, 1'b0);
        applyStimulus(3, 8'h77, 1'b1);
        runFrame("hold0", 8'h44, 2'd1);
        a0 = acc;
        repeat (500) step();
        checkOutput("hold_no_accept", 32'(acc - a0), 0);
        checkOutput("hold_gid", 32'(grant_id), 1);
        checkOutput("hold_busy", 32'(busy), 0);
        applyStimulus(1, 8'h55, 1'b1);
        runFrame("hold1", 8'h55, 2'd1);
        runFrame("hold2", 8'h77, 2'd3);

        $display("[TB] gap timing");
        doReset();
        applyStimulus(0, 8'h3C, 1'b1);
        waitStart();
        checkOutput("gap_first_txin", 32'(uart_txin), 32'h3C);
        step();
        step();
        pulseDone();
        applyStimulus(1, 8'h4D, 1'b1);
        n = 1;
        step();
        n++;
        uart_txdone = 1'b1;
        step();
        n++;
        uart_txdone = 1'b0;
        for (int i = 0; i < 30 && !uart_start; i++) begin
            step();
            n++;
        end
        checkOutput("gap_launch_offset", 32'(n), GAP + 2);
        checkOutput("gap_second_txin", 32'(uart_txin), 32'h4D);
        checkOutput("gap_second_gid", 32'(grant_id), 1);
        step();
        step();
        pulseDone();
        waitIdle();

        $display("[TB] reset mid-frame");
        doReset();
        applyStimulus(2, 8'h5A, 1'b1);
        waitStart();
        step();
        step();
        checkOutput("rstmid_busy_before", 32'(busy), 1);
        checkOutput("rstmid_txin_before", 32'(uart_txin), 32'h5A);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_busy", 32'(busy), 0);
        checkOutput("rstmid_txin", 32'(uart_txin), 0);
        checkOutput("rstmid_gid", 32'(grant_id), 3);
        checkOutput("rstmid_start", 32'(uart_start), 0);
        checkOutput("rstmid_ready", 32'(req_ready), 0);
        doReset();
        applyStimulus(2, 8'h66, 1'b1);
        runFrame("after_rst", 8'h66, 2'd2);

`ifdef UART_ARB_WDOG_EN
        $display("[TB] watchdog");
        doReset();
        applyStimulus(0, 8'hE1, 1'b0);
        applyStimulus(0, 8'hE3, 1'b1);
        applyStimulus(1, 8'hE2, 1'b1);
        waitStart();
        checkOutput("wdog_first_txin", 32'(uart_txin), 32'hE1);
        n = 0;
        for (int i = 0; i < 200 && !wdog_err; i++) begin
            step();
            n++;
        end
        checkOutput("wdog_cycle", 32'(n), WD);
        step();
        checkOutput("wdog_pulse_once", 32'(wdog_err), 0);
        checkOutput("wdog_in_gap", 32'(busy), 1);
        waitIdle();
        runFrame("wdog_next", 8'hE2, 2'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
